// File: rtl/accum_block.sv
// accum_block
// -----------
// Accumulate-and-dump unit. Each accepted operand is added to or subtracted
// from a running WIDTH-bit register, using unsigned or two's-complement
// rules, with either wrap-around or saturation on overflow. Carry/borrow,
// sticky overflow and zero are reported. When dump_len is non-zero, every
// dump_len operations the result is copied into dump_data, dump_valid
// pulses for one cycle and the accumulator restarts from zero.
//
// Ports
//   clk         in   rising-edge clock
//   clr         in   asynchronous active-low reset
//   en          in   operand valid (accepted every edge, no backpressure)
//   sub         in   1 = acc - din, 0 = acc + din
//   signed_mode in   1 = two's-complement, 0 = unsigned
//   sat         in   1 = saturate on overflow, 0 = wrap
//   load        in   load din into acc (beats en)
//   din         in   operand, WIDTH bits
//   dump_len    in   ops per block, 0 = free-running
//   acc         out  accumulator
//   carry       out  raw carry (add) / borrow (sub) of last op
//   ovf         out  sticky overflow for the current block
//   zero        out  acc == 0
//   count       out  ops accepted in the current block
//   dump_valid  out  one-cycle pulse when a block result is produced
//   dump_data   out  last block result
//   dump_ovf    out  overflow state of the last dumped block

module accum_block #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               sub,
  input  logic               signed_mode,
  input  logic               sat,
  input  logic               load,
  input  logic [WIDTH-1:0]   din,
  input  logic [COUNT_W-1:0] dump_len,
  output logic [WIDTH-1:0]   acc,
  output logic               carry,
  output logic               ovf,
  output logic               zero,
  output logic [COUNT_W-1:0] count,
  output logic               dump_valid,
  output logic [WIDTH-1:0]   dump_data,
  output logic               dump_ovf
);

  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_ovf;
  logic [COUNT_W-1:0] r_count;
  logic               r_dump_valid;
  logic [WIDTH-1:0]   r_dump_data;
  logic               r_dump_ovf;

  logic [WIDTH:0]     w_sum;
  logic               w_acc_sign;
  logic               w_din_sign;
  logic               w_res_sign;
  logic               w_ovf_unsigned;
  logic               w_ovf_signed;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_sat_val;
  logic [WIDTH-1:0]   w_next_acc;
  logic [COUNT_W:0]   w_count_inc;
  logic               w_dump;
  logic [COUNT_W-1:0] w_count_next;

  // Arithmetic datapath: raw sum/difference, overflow detection, saturation.
  always_comb begin
    w_sum = {(WIDTH+1){1'b0}};
    if (sub) begin
      w_sum = {1'b0, r_acc} - {1'b0, din};
    end else begin
      w_sum = {1'b0, r_acc} + {1'b0, din};
    end

    w_acc_sign = r_acc[WIDTH-1];
    w_din_sign = din[WIDTH-1];
    w_res_sign = w_sum[WIDTH-1];

    // Unsigned: carry out on add, acc < din on subtract (== borrow).
    if (sub) begin
      w_ovf_unsigned = (r_acc < din);
    end else begin
      w_ovf_unsigned = w_sum[WIDTH];
    end

    // Signed: add overflows when operands agree in sign and the result does
    // not; subtract overflows when operands differ and result leaves acc's sign.
    if (sub) begin
      w_ovf_signed = (w_acc_sign != w_din_sign) && (w_res_sign != w_acc_sign);
    end else begin
      w_ovf_signed = (w_acc_sign == w_din_sign) && (w_res_sign != w_acc_sign);
    end

    if (signed_mode) begin
      w_ovf = w_ovf_signed;
    end else begin
      w_ovf = w_ovf_unsigned;
    end

    // On signed overflow the true result always has acc's sign, so acc's
    // sign bit picks the clamp direction.
    if (signed_mode) begin
      if (w_acc_sign) begin
        w_sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_sat_val = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      if (sub) begin
        w_sat_val = {WIDTH{1'b0}};
      end else begin
        w_sat_val = {WIDTH{1'b1}};
      end
    end

    if (sat && w_ovf) begin
      w_next_acc = w_sat_val;
    end else begin
      w_next_acc = w_sum[WIDTH-1:0];
    end
  end

  // Block counter: one extra bit so the >= compare also covers a count that
  // saturated while free-running.
  always_comb begin
    w_count_inc = {1'b0, r_count} + {{COUNT_W{1'b0}}, 1'b1};
    w_dump      = (dump_len != {COUNT_W{1'b0}}) &&
                  (w_count_inc >= {1'b0, dump_len});
    if (w_count_inc[COUNT_W]) begin
      w_count_next = r_count;
    end else begin
      w_count_next = w_count_inc[COUNT_W-1:0];
    end
  end

  // State update: clr > load > en; dump_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_acc        <= {WIDTH{1'b0}};
      r_carry      <= 1'b0;
      r_ovf        <= 1'b0;
      r_count      <= {COUNT_W{1'b0}};
      r_dump_valid <= 1'b0;
      r_dump_data  <= {WIDTH{1'b0}};
      r_dump_ovf   <= 1'b0;
    end else begin
      r_dump_valid <= 1'b0;
      if (load) begin
        r_acc   <= din;
        r_count <= {COUNT_W{1'b0}};
        r_ovf   <= 1'b0;
        r_carry <= 1'b0;
      end else if (en) begin
        r_carry <= w_sum[WIDTH];
        if (w_dump) begin
          r_dump_data  <= w_next_acc;
          r_dump_ovf   <= r_ovf | w_ovf;
          r_dump_valid <= 1'b1;
          r_acc        <= {WIDTH{1'b0}};
          r_count      <= {COUNT_W{1'b0}};
          r_ovf        <= 1'b0;
        end else begin
          r_acc   <= w_next_acc;
          r_count <= w_count_next;
          r_ovf   <= r_ovf | w_ovf;
        end
      end else begin
        r_acc   <= r_acc;
        r_count <= r_count;
      end
    end
  end

  assign acc        = r_acc;
  assign carry      = r_carry;
  assign ovf        = r_ovf;
  assign zero       = (r_acc == {WIDTH{1'b0}});
  assign count      = r_count;
  assign dump_valid = r_dump_valid;
  assign dump_data  = r_dump_data;
  assign dump_ovf   = r_dump_ovf;

endmodule

// File: tb/tb_accum_block.sv
// Testbench for accum_block (WIDTH=8, COUNT_W=4). A behavioural model using
// integer arithmetic predicts every output; a negedge process compares the
// DUT against it each cycle, and directed literal checks pin the model.

module tb_accum_block;

  logic       clk = 1'b0;
  logic       clr;
  logic       t_en, t_sub, t_sm, t_sat, t_load;
  logic [7:0] t_din;
  logic [3:0] t_dl;

  logic [7:0] acc, dump_data;
  logic       carry, ovf, zero, dump_valid, dump_ovf;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  typedef struct packed {
    logic [7:0] acc;
    logic       carry;
    logic       ovf;
    logic [3:0] count;
    logic       dv;
    logic [7:0] dd;
    logic       dovf;
  } st_t;

  st_t m = '0;

  accum_block #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .clr(clr), .en(t_en), .sub(t_sub), .signed_mode(t_sm),
    .sat(t_sat), .load(t_load), .din(t_din), .dump_len(t_dl),
    .acc(acc), .carry(carry), .ovf(ovf), .zero(zero), .count(count),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ovf(dump_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: compute the true mathematical result and judge it.
  function automatic st_t model_step(st_t s, bit ld, bit e, bit sb, bit sm,
                                     bit st, logic [7:0] d, logic [3:0] dl);
    st_t n;
    int ua, ud, ut, sa, sd, t, res, nc;
    bit o;
    n = s;
    n.dv = 1'b0;
    if (ld) begin
      n.acc = d; n.count = 4'd0; n.ovf = 1'b0; n.carry = 1'b0;
    end else if (e) begin
      ua = int'(s.acc);
      ud = int'(d);
      ut = sb ? ua - ud : ua + ud;
      n.carry = sb ? (ua < ud) : (ut > 255);
      if (!sm) begin
        o = (ut < 0) || (ut > 255);
        if (st && o) res = (ut < 0) ? 0 : 255;
        else         res = ut & 255;
      end else begin
        sa = (ua > 127) ? ua - 256 : ua;
        sd = (ud > 127) ? ud - 256 : ud;
        t  = sb ? sa - sd : sa + sd;
        o  = (t > 127) || (t < -128);
        if (st && o) res = (t > 127) ? 127 : 128;
        else         res = t & 255;
      end
      nc = int'(s.count) + 1;
      if (dl != 4'd0 && nc >= int'(dl)) begin
        n.dd    = res[7:0];
        n.dovf  = s.ovf | o;
        n.dv    = 1'b1;
        n.acc   = 8'd0;
        n.count = 4'd0;
        n.ovf   = 1'b0;
      end else begin
        n.acc   = res[7:0];
        n.count = (nc > 15) ? 4'd15 : nc[3:0];
        n.ovf   = s.ovf | o;
      end
    end
    return n;
  endfunction

  // Model state follows the same asynchronous reset as the DUT.
  always @(posedge clk or negedge clr) begin
    if (!clr) m <= '0;
    else      m <= model_step(m, t_load, t_en, t_sub, t_sm, t_sat, t_din, t_dl);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("acc",        {24'd0, acc},       {24'd0, m.acc});
      check("carry",      {31'd0, carry},     {31'd0, m.carry});
      check("ovf",        {31'd0, ovf},       {31'd0, m.ovf});
      check("zero",       {31'd0, zero},      {31'd0, (m.acc == 8'd0)});
      check("count",      {28'd0, count},     {28'd0, m.count});
      check("dump_valid", {31'd0, dump_valid},{31'd0, m.dv});
      check("dump_data",  {24'd0, dump_data}, {24'd0, m.dd});
      check("dump_ovf",   {31'd0, dump_ovf},  {31'd0, m.dovf});
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the edge.
  task automatic cyc(input bit ld, input bit e, input bit sb, input bit sm,
                     input bit st, input logic [7:0] d, input logic [3:0] dl);
    t_load = ld; t_en = e; t_sub = sb; t_sm = sm; t_sat = st;
    t_din = d; t_dl = dl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b1;
    t_load = 1'b0; t_en = 1'b0; t_sub = 1'b0; t_sm = 1'b0; t_sat = 1'b0;
    t_din = 8'd0; t_dl = 4'd0;
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b1;
    chk_on = 1'b1;

    // Async reset mid-block
    cyc(0, 1, 0, 0, 0, 8'h11, 4'd0);
    cyc(0, 1, 0, 0, 0, 8'h22, 4'd0);
    check("build_acc",   {24'd0, acc},   32'h33);
    check("build_count", {28'd0, count}, 32'd2);
    t_din = 8'h01;
    clr = 1'b0;
    #1;
    check("rst_acc",   {24'd0, acc},   32'h0);
    check("rst_count", {28'd0, count}, 32'h0);
    check("rst_zero",  {31'd0, zero},  32'h1);
    #3 clr = 1'b1;
    cyc(0, 1, 0, 0, 0, 8'h01, 4'd0);
    check("post_rst_acc", {24'd0, acc}, 32'h01);

    // Unsigned wrap
    cyc(1, 0, 0, 0, 0, 8'hF0, 4'd0);
    cyc(0, 1, 0, 0, 0, 8'h20, 4'd0);
    check("wrap_acc",   {24'd0, acc},   32'h10);
    check("wrap_carry", {31'd0, carry}, 32'h1);
    check("wrap_ovf",   {31'd0, ovf},   32'h1);
    cyc(0, 1, 0, 0, 0, 8'h01, 4'd0);
    check("wrap2_acc",   {24'd0, acc},   32'h11);
    check("wrap2_carry", {31'd0, carry}, 32'h0);
    check("wrap2_ovf",   {31'd0, ovf},   32'h1);

    // Signed saturation
    cyc(1, 0, 0, 1, 1, 8'h70, 4'd0);
    cyc(0, 1, 0, 1, 1, 8'h20, 4'd0);
    check("ssat_pos_acc", {24'd0, acc}, 32'h7F);
    check("ssat_pos_ovf", {31'd0, ovf}, 32'h1);
    cyc(1, 0, 0, 1, 1, 8'h80, 4'd0);
    cyc(0, 1, 1, 1, 1, 8'h01, 4'd0);
    check("ssat_neg_acc", {24'd0, acc}, 32'h80);
    check("ssat_neg_ovf", {31'd0, ovf}, 32'h1);

    // Unsigned saturation on borrow
    cyc(1, 0, 0, 0, 1, 8'h05, 4'd0);
    cyc(0, 1, 1, 0, 1, 8'h09, 4'd0);
    check("usat_acc",   {24'd0, acc},   32'h00);
    check("usat_carry", {31'd0, carry}, 32'h1);

    // Dump every 4 ops
    cyc(1, 0, 0, 0, 0, 8'h00, 4'd4);
    cyc(0, 1, 0, 0, 0, 8'h01, 4'd4);
    cyc(0, 1, 0, 0, 0, 8'h02, 4'd4);
    cyc(0, 1, 0, 0, 0, 8'h03, 4'd4);
    cyc(0, 1, 0, 0, 0, 8'h04, 4'd4);
    check("dump_valid", {31'd0, dump_valid}, 32'h1);
    check("dump_data",  {24'd0, dump_data},  32'h0A);
    check("dump_ovf",   {31'd0, dump_ovf},   32'h0);
    check("dump_acc",   {24'd0, acc},        32'h0);
    check("dump_count", {28'd0, count},      32'h0);
    cyc(0, 1, 0, 0, 0, 8'h07, 4'd4);
    check("after_dump_acc",   {24'd0, acc},        32'h07);
    check("after_dump_count", {28'd0, count},      32'h1);
    check("after_dump_dv",    {31'd0, dump_valid}, 32'h0);

    // load beats en
    cyc(1, 1, 0, 0, 0, 8'h42, 4'd0);
    check("ld_en_acc",   {24'd0, acc},        32'h42);
    check("ld_en_count", {28'd0, count},      32'h0);
    check("ld_en_dv",    {31'd0, dump_valid}, 32'h0);

    // Lowering dump_len below count forces a dump
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 8'h01, 4'd0);
    check("free_count", {28'd0, count}, 32'd5);
    cyc(0, 1, 0, 0, 0, 8'h01, 4'd2);
    check("force_dump_dv",    {31'd0, dump_valid}, 32'h1);
    check("force_dump_data",  {24'd0, dump_data},  32'h48);
    check("force_dump_count", {28'd0, count},      32'h0);

    // Randomized traffic with occasional async reset pulses
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        clr = 1'b0;
        #2 clr = 1'b1;
      end
      cyc($urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
    end

    cyc(0, 0, 0, 0, 0, 8'h00, 4'd0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_block.md
# accum_block

Parametrised accumulate-and-dump unit for the lab datapath. It adds or subtracts one WIDTH-bit operand per accepted cycle into a running register. Operands are treated as unsigned or two's-complement, and results either wrap or saturate. It reports carry/borrow, sticky overflow and zero. It optionally emits a block result every `dump_len` operations and auto-clears; downstream display or LED logic consumes `acc` and `dump_*`.

## Interface
- `WIDTH`, default 8: accumulator and operand width (≥2).
- `COUNT_W`, default 4: operation-counter width; block length range 1..2^COUNT_W−1.
- `clk`, in, 1: single clock, rising edge.
- `clr`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: operand valid; op accepted on every rising edge with `en`=1 (no backpressure).
- `sub`, in, 1: 1 = acc − din, 0 = acc + din.
- `signed_mode`, in, 1: 1 = two's-complement arithmetic, 0 = unsigned.
- `sat`, in, 1: 1 = saturate on overflow, 0 = wrap.
- `load`, in, 1: load `din` directly into acc.
- `din`, in, WIDTH: operand.
- `dump_len`, in, COUNT_W: ops per block; 0 = free-running (never dump).
- `acc`, out, WIDTH: accumulator register.
- `carry`, out, 1: raw carry (add) / borrow (sub) of the last accepted op.
- `ovf`, out, 1: sticky overflow.
- `zero`, out, 1: `acc` == 0 (combinational from register).
- `count`, out, COUNT_W: ops accepted in the current block.
- `dump_valid`, out, 1: one-cycle pulse, block result available.
- `dump_data`, out, WIDTH: block result, held until the next dump.
- `dump_ovf`, out, 1: `ovf` state for the dumped block, held with `dump_data`.

## Operation
- Priority: `clr` low > `load` > `en`. If `load` and `en` are both high, `load` wins and the op is discarded.
- `clr` low: all registers and outputs go to 0 immediately (`acc`, `carry`, `ovf`, `count`, `dump_valid`, `dump_data`, `dump_ovf`); `zero`=1.
- `load`: acc←din, count←0, ovf←0, carry←0; no dump is generated.
- Op: form a WIDTH+1-bit result r = {0,acc} ± {0,din}; carry←r[WIDTH].
- Overflow, unsigned: add → r[WIDTH]=1; sub → acc < din.
- Overflow, signed: operand signs per two's-complement rule (add: same signs, result sign differs; sub: signs differ, result sign differs from acc).
- Wrap (`sat`=0): acc←r[WIDTH−1:0].
- Saturate (`sat`=1), only when the op overflows:
  - Unsigned add → all ones; unsigned sub → 0.
  - Signed: positive true result → 0111…1; negative → 1000…0.
- ovf←ovf | overflow. Cleared only by `clr`, `load` or a dump.
- count: +1 per op. In free-running mode it saturates at all ones.
- Dump: when `dump_len`≠0 and count+1 ≥ `dump_len` on an accepted op, the same edge does:
  - dump_data←new acc value; dump_ovf←ovf | overflow; dump_valid←1;
  - acc←0; count←0; ovf←0.
- The ≥ comparison forces a dump on the next op if `dump_len` is lowered below `count` mid-block.
- `sub`, `signed_mode`, `sat` and `dump_len` are sampled per op and may change every cycle.

## Timing
- Latency 1 cycle: `acc`, `carry`, `ovf` and `count` reflect an op on the edge it is accepted.
- `dump_valid` is high exactly one cycle after the dumping edge, then 0 unless the next op also dumps (`dump_len`=1 → pulse every op).
- An op accepted in the `dump_valid` cycle starts the new block from acc=0.
- With no `en` and no `load`, all registers hold and `dump_valid` drops to 0.
- `clr` asserted mid-block or during `dump_valid` aborts immediately; release takes effect on the first rising edge with `clr`=1.

## Test plan
- Async reset: build acc=0x33, count=2, then pull `clr` low between edges → all outputs 0 and `zero`=1 before the next edge; release → first op add 0x01 gives acc=0x01.
- Unsigned wrap (WIDTH=8, sat=0): load 0xF0, add 0x20 → acc=0x10, carry=1, ovf=1; add 0x01 → acc=0x11, carry=0, ovf still 1.
- Saturation:
  - signed, sat=1: load 0x70, add 0x20 → acc=0x7F, ovf=1; load 0x80, sub 0x01 → acc=0x80, ovf=1.
  - unsigned: load 0x05, sub 0x09 → acc=0x00, carry=1.
- Dump (dump_len=4, wrap, unsigned): add 1,2,3,4 back-to-back → next cycle dump_valid=1, dump_data=0x0A, dump_ovf=0, acc=0, count=0; an add of 7 in that cycle → acc=0x07, count=1, dump_valid=0.
- Simultaneous/boundary: `load`=1 and `en`=1 with din=0x42 → acc=0x42, count=0, no dump; dump_len 0→2 while count=5 → next op dumps.
